// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_tree_pkg.sv
// Shared constants and helpers for the pipelined wide-OR reduction tree.
//   OR_TREE_FANIN     : inputs per OR group at every tree level
//   OR_TREE_MAX_WIDTH : largest supported WIDTH
//   clog4(n)          : ceil(log4(n)), never less than 1
package gf180mcu_fd_sc_mcu9t5v0__or_tree_pkg;

  localparam int unsigned OR_TREE_FANIN     = 4;
  localparam int unsigned OR_TREE_MAX_WIDTH = 256;

  // Loop is bounded so it stays a legal constant function for any input.
  function automatic int unsigned clog4(input int unsigned n);
    int unsigned l;
    int unsigned cap;
    l   = 1;
    cap = OR_TREE_FANIN;
    for (int i = 0; i < 16; i++) begin
      if (cap < n) begin
        cap = cap * OR_TREE_FANIN;
        l   = l + 1;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_tree_lvl.sv
// One registered level of the OR tree: each output bit is the OR of four
// adjacent input bits, captured every cycle.
// Ports:
//   CLK : rising-edge clock
//   RN  : synchronous active-low reset, clears Q
//   D   : NIN level inputs (NIN must be a multiple of 4)
//   Q   : NIN/4 registered group ORs
module gf180mcu_fd_sc_mcu9t5v0__or_tree_lvl
  import gf180mcu_fd_sc_mcu9t5v0__or_tree_pkg::*;
#(
  parameter int unsigned NIN = 4
) (
  input  logic                           CLK,
  input  logic                           RN,
  input  logic [NIN-1:0]                 D,
  output logic [NIN/OR_TREE_FANIN-1:0]   Q
);

  localparam int unsigned NOUT = NIN / OR_TREE_FANIN;

  logic [NOUT-1:0] w_or;
  logic [NOUT-1:0] r_q;

  // OR4 groups
  always_comb begin
    w_or = '0;
    for (int unsigned g = 0; g < NOUT; g++) begin
      w_or[g] = |D[g*OR_TREE_FANIN +: OR_TREE_FANIN];
    end
  end

  // Free-running level register
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_q <= '0;
    end else begin
      r_q <= w_or;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_tree_pipe.sv
// Pipelined wide-OR reduction: WIDTH inputs reduced through LEVELS registered
// OR4 levels, with a valid tag shifted alongside the data.
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__OR_TREE_STICKY_EN
//   adds CLR and a sticky stage after the tree (latency LEVELS+1).
// Ports:
//   CLK : rising-edge clock
//   RN  : synchronous active-low reset, clears all levels and tags
//   CLR : (sticky build only) synchronous active-high sticky clear
//   VI  : input-valid tag for A
//   A   : WIDTH OR operands
//   Z   : registered OR of A (or sticky result)
//   ZV  : valid tag aligned with Z
module gf180mcu_fd_sc_mcu9t5v0__or_tree_pipe
  import gf180mcu_fd_sc_mcu9t5v0__or_tree_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RN,
`ifdef GF180MCU_FD_SC_MCU9T5V0__OR_TREE_STICKY_EN
  input  logic             CLR,
`endif
  input  logic             VI,
  input  logic [WIDTH-1:0] A,
  output logic             Z,
  output logic             ZV
);

  localparam int unsigned LEVELS = clog4(WIDTH);
  localparam int unsigned PADW   = 32'(4**LEVELS);
  // All levels packed smallest-first: the level of width 4^m sits at offset
  // (4^m-1)/3, so the final 1-bit level is bit 0 and the padded input is on top.
  localparam int unsigned TOTAL  = (4*PADW - 1) / 3;

  logic [TOTAL-1:0]  w_tree;
  logic [LEVELS-1:0] r_v;
  logic              w_z;
  logic              w_zv;

  // Level 0: operands zero-padded to 4^LEVELS bits
  assign w_tree[(PADW-1)/3 +: PADW] = PADW'(A);

  genvar k;
  generate
    for (k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned M       = LEVELS - k;
      localparam int unsigned NOUT    = 32'(4**M);
      localparam int unsigned NIN     = 4 * NOUT;
      localparam int unsigned OUT_OFF = (NOUT - 1) / 3;
      localparam int unsigned IN_OFF  = (NIN - 1) / 3;

      gf180mcu_fd_sc_mcu9t5v0__or_tree_lvl #(
        .NIN (NIN)
      ) u_lvl (
        .CLK (CLK),
        .RN  (RN),
        .D   (w_tree[IN_OFF +: NIN]),
        .Q   (w_tree[OUT_OFF +: NOUT])
      );
    end
  endgenerate

  // Valid shift chain, one stage per tree level
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_v <= '0;
    end else begin
      r_v[0] <= VI;
      for (int unsigned i = 1; i < LEVELS; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  assign w_z  = w_tree[0];
  assign w_zv = r_v[LEVELS-1];

`ifdef GF180MCU_FD_SC_MCU9T5V0__OR_TREE_STICKY_EN
  logic r_s;
  logic r_sv;

  // Sticky capture: a new qualified 1 wins over a coincident clear
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_s  <= 1'b0;
      r_sv <= 1'b0;
    end else begin
      r_s  <= (r_s & ~CLR) | (w_zv & w_z);
      r_sv <= w_zv;
    end
  end

  assign Z  = r_s;
  assign ZV = r_sv;
`else
  assign Z  = w_z;
  assign ZV = w_zv;
`endif

endmodule
